// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   - FSM state encoding (IDLE, OWN, TURN)
//   - clog2 helper used for index/counter widths
//   - default requester count and the matching index width
package bus_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;  // bus unowned, waiting for any request
    localparam logic [1:0] ST_OWN  = 2'd1;  // one requester holds the bus
    localparam logic [1:0] ST_TURN = 2'd2;  // all drivers off between tenures

    // Ceiling log2, never less than 1 so a width is always legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    localparam int DEF_NREQ  = 4;
    localparam int DEF_IDX_W = clog2(DEF_NREQ);

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick.
// Finds the first set bit of req scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
// Ports:
//   req    in  NREQ   request vector
//   ptr    in  IDX_W  index with highest priority (must be < NREQ)
//   onehot out NREQ   one-hot of the picked requester, 0 if none
//   idx    out IDX_W  index of the picked requester, 0 if none
//   any    out 1      at least one request is set
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(NREQ);

    logic [NREQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]  sum;

    // Rotate so that bit 0 of rot corresponds to req[ptr]; the doubled copy
    // makes the wrap-around fall out of a plain right shift.
    assign rot = NREQ'({req, req} >> ptr);

    // Lowest set bit of the rotated vector is the offset from ptr.
    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDX_W'(k);
            end
        end
    end

    assign any = |rot;

    // Undo the rotation: idx = (ptr + off) mod NREQ.
    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = !any ? '0 : ((sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum));

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign onehot[gi] = any && (idx == IDX_W'(gi));
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for a shared tristate data bus.
// Issues a registered one-hot grant and per-requester output enables, caps a
// tenure at MAX_BURST cycles while others wait, and inserts TA_CYCLES
// all-off cycles between owners so drivers never overlap.
// Ports:
//   clk        in  1      system clock, rising edge
//   rst        in  1      asynchronous active-low reset
//   req        in  NREQ   level request per requester
//   grant      out NREQ   registered one-hot grant, 0 when unowned
//   bus_oe     out NREQ   tristate enable per requester (grant while owning)
//   owner      out IDX_W  current owner index, 0 when not busy
//   busy       out 1      bus is owned
//   turnaround out 1      bus is in the dead gap between owners
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int MAX_BURST = 4,
    parameter int TA_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        bus_oe,
    output logic [clog2(NREQ)-1:0] owner,
    output logic                   busy,
    output logic                   turnaround
);

    localparam int IDX_W = clog2(NREQ);
    localparam int BC_W  = clog2(MAX_BURST + 1);
    localparam int TA_W  = clog2(TA_CYCLES + 1);

    localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
    localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(MAX_BURST);
    localparam logic [TA_W-1:0]  TA_LOAD = TA_W'(TA_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NREQ - 1);

    logic [1:0]       state_reg, state_next;
    logic [NREQ-1:0]  grant_reg, grant_next;
    logic [NREQ-1:0]  bus_oe_reg, bus_oe_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic             busy_reg, busy_next;
    logic             turn_reg, turn_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [BC_W-1:0]  burst_cnt_reg, burst_cnt_next;
    logic [TA_W-1:0]  ta_cnt_reg, ta_cnt_next;

    logic [NREQ-1:0]  pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [IDX_W-1:0] owner_inc;
    logic             owner_req;
    logic             others_wait;

    // ptr is only updated on entry to TURN, so the pick made on the final TURN
    // edge already starts just past the previous owner.
    rr_priority_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign owner_inc   = (owner_reg == IDX_TOP) ? '0 : owner_reg + IDX_W'(1);
    assign owner_req   = req[owner_reg];
    assign others_wait = |(req & ~grant_reg);

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        owner_next     = owner_reg;
        busy_next      = busy_reg;
        turn_next      = turn_reg;
        ptr_next       = ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        ta_cnt_next    = ta_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next     = ST_OWN;
                    grant_next     = pick_onehot;
                    owner_next     = pick_idx;
                    busy_next      = 1'b1;
                    burst_cnt_next = BC_ONE;
                end
            end

            ST_OWN: begin
                if (!owner_req || (burst_cnt_reg == BC_MAX && others_wait)) begin
                    state_next     = ST_TURN;
                    grant_next     = '0;
                    owner_next     = '0;
                    busy_next      = 1'b0;
                    turn_next      = 1'b1;
                    ptr_next       = owner_inc;
                    burst_cnt_next = '0;
                    ta_cnt_next    = TA_LOAD;
                end else if (burst_cnt_reg == BC_MAX) begin
                    // Lone requester: keep the bus, just restart the burst count.
                    burst_cnt_next = BC_ONE;
                end else begin
                    burst_cnt_next = burst_cnt_reg + BC_ONE;
                end
            end

            ST_TURN: begin
                if (ta_cnt_reg == '0) begin
                    turn_next = 1'b0;
                    if (pick_any) begin
                        state_next     = ST_OWN;
                        grant_next     = pick_onehot;
                        owner_next     = pick_idx;
                        busy_next      = 1'b1;
                        burst_cnt_next = BC_ONE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    ta_cnt_next = ta_cnt_reg - TA_W'(1);
                end
            end

            default: begin
                state_next     = ST_IDLE;
                grant_next     = '0;
                owner_next     = '0;
                busy_next      = 1'b0;
                turn_next      = 1'b0;
                burst_cnt_next = '0;
                ta_cnt_next    = '0;
            end
        endcase

        bus_oe_next = (state_next == ST_OWN) ? grant_next : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            bus_oe_reg    <= '0;
            owner_reg     <= '0;
            busy_reg      <= 1'b0;
            turn_reg      <= 1'b0;
            ptr_reg       <= '0;
            burst_cnt_reg <= '0;
            ta_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            bus_oe_reg    <= bus_oe_next;
            owner_reg     <= owner_next;
            busy_reg      <= busy_next;
            turn_reg      <= turn_next;
            ptr_reg       <= ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            ta_cnt_reg    <= ta_cnt_next;
        end
    end

    assign grant      = grant_reg;
    assign bus_oe     = bus_oe_reg;
    assign owner      = owner_reg;
    assign busy       = busy_reg;
    assign turnaround = turn_reg;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter. Two instances share clk/rst/req:
// dut_a uses TA_CYCLES=1, dut_b uses TA_CYCLES=3. A tenure-level reference
// model (current owner, cycles held, dead cycles left, next start index)
// predicts every output of both instances.
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;

    logic [3:0] grant_a, oe_a, grant_b, oe_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, turn_a, busy_b, turn_b;

    bus_rr_arbiter #(.NREQ(N), .MAX_BURST(MB), .TA_CYCLES(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant_a),
        .bus_oe     (oe_a),
        .owner      (owner_a),
        .busy       (busy_a),
        .turnaround (turn_a)
    );

    bus_rr_arbiter #(.NREQ(N), .MAX_BURST(MB), .TA_CYCLES(3)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant_b),
        .bus_oe     (oe_b),
        .owner      (owner_b),
        .busy       (busy_b),
        .turnaround (turn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [11:0] act_a = {grant_a, oe_a, owner_a, busy_a, turn_a};
    wire [11:0] act_b = {grant_b, oe_b, owner_b, busy_b, turn_b};

    // ---------------- reference model ----------------
    typedef struct {
        int owner;  // -1 when nobody holds the bus
        int held;   // cycles the current owner has held it in this burst
        int gap;    // dead cycles still to show
        int ptr;    // where the next round-robin search starts
    } mstate_t;

    localparam mstate_t M_RESET = '{owner: -1, held: 0, gap: 0, ptr: 0};

    mstate_t m_a, m_b;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    function automatic int rr_pick(logic [3:0] r, int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic mstate_t mstep(mstate_t s, logic [3:0] r, int ta);
        mstate_t n;
        n = s;
        if (s.owner >= 0) begin
            logic [3:0] others;
            others = r & ~(4'b0001 << s.owner);
            if (!r[s.owner] || (s.held == MB && others != 4'b0)) begin
                n.owner = -1;
                n.held  = 0;
                n.gap   = ta;
                n.ptr   = (s.owner + 1) % N;
            end else if (s.held == MB) begin
                n.held = 1;
            end else begin
                n.held = s.held + 1;
            end
        end else if (s.gap > 0) begin
            n.gap = s.gap - 1;
            if (n.gap == 0 && r != 4'b0) begin
                n.owner = rr_pick(r, s.ptr);
                n.held  = 1;
            end
        end else if (r != 4'b0) begin
            n.owner = rr_pick(r, s.ptr);
            n.held  = 1;
        end
        return n;
    endfunction

    // Expected {grant, bus_oe, owner, busy, turnaround}
    function automatic logic [11:0] exp_vec(mstate_t s);
        logic [3:0] g;
        logic [1:0] o;
        g = (s.owner >= 0) ? (4'b0001 << s.owner) : 4'b0000;
        o = (s.owner >= 0) ? 2'(s.owner) : 2'b00;
        return {g, g, o, (s.owner >= 0), (s.gap > 0)};
    endfunction

    // One clock: model consumes the req seen at the edge, returns at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_a = mstep(m_a, req, 1);
            m_b = mstep(m_b, req, 3);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0;
        m_a = M_RESET;
        m_b = M_RESET;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_cmp++;
        if (act_a !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_state cyc=%0d got=%h want=%h", cyc, act_a, 12'h000);
        end
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        // Async reset in the middle of a cycle, with no clock edge.
        #2;
        rst = 1'b0;
        m_a = M_RESET;
        m_b = M_RESET;
        #1;
        n_cmp++;
        if ({grant_a, oe_a, grant_b, oe_b} !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_reset cyc=%0d got=%h want=%h", cyc, {grant_a, oe_a, grant_b, oe_b}, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_cmp++;
        if (act_a !== {4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_first_grant cyc=%0d got=%h want=%h", cyc, act_a, {4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_lone();
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (act_a !== {4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0} || act_a !== exp_vec(m_a)) begin
                n_bad++;
                $display("FAIL lone cyc=%0d got=%h want=%h", cyc, act_a, exp_vec(m_a));
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 25; i++) begin
            logic [3:0] want;
            int ph;
            tick();
            ph   = i % 10;
            want = (ph < 4) ? 4'b0001 : (ph == 4 || ph == 9) ? 4'b0000 : 4'b0010;
            n_cmp++;
            if (grant_a !== want || act_a !== exp_vec(m_a)) begin
                n_bad++;
                $display("FAIL contention cyc=%0d got=%h want=%h (grant %b/%b)", cyc, act_a, exp_vec(m_a), grant_a, want);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0101;
        tick();
        tick();
        req = 4'b0100;
        tick();
        n_cmp++;
        if (act_a !== {4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL early_release_turn cyc=%0d got=%h want=%h", cyc, act_a, {4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1});
        end
        tick();
        n_cmp++;
        if (act_a !== {4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0} || act_a !== exp_vec(m_a)) begin
            n_bad++;
            $display("FAIL early_release_grant cyc=%0d got=%h want=%h", cyc, act_a, {4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
        end
    endtask

    task automatic test_wrap();
        int  zeros_b;
        bit  seen_b;
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b1001;
        zeros_b = 0;
        seen_b  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!seen_b) begin
                if (grant_b == 4'b0001) seen_b = 1;
                else if (turn_b) zeros_b++;
            end
            n_cmp++;
            if (act_a !== exp_vec(m_a) || act_b !== exp_vec(m_b)) begin
                n_bad++;
                $display("FAIL wrap cyc=%0d got=%h/%h want=%h/%h", cyc, act_a, act_b, exp_vec(m_a), exp_vec(m_b));
            end
            if (i == 4) begin
                n_cmp++;
                if (grant_a !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL wrap_to_0 cyc=%0d got=%b want=%b", cyc, grant_a, 4'b0001);
                end
            end
        end
        n_cmp++;
        if (zeros_b != 3 || !seen_b) begin
            n_bad++;
            $display("FAIL ta3_gap cyc=%0d got=%0d want=3 (reached=%0d)", cyc, zeros_b, seen_b);
        end
    endtask

    task automatic test_idle();
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (act_a !== exp_vec(m_a)) begin
                n_bad++;
                $display("FAIL idle_fall cyc=%0d got=%h want=%h", cyc, act_a, exp_vec(m_a));
            end
        end
        n_cmp++;
        if (busy_a !== 1'b0 || turn_a !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_state cyc=%0d got=%b%b want=00", cyc, busy_a, turn_a);
        end
        req = 4'b1000;
        tick();
        n_cmp++;
        if (act_a !== {4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_new_req cyc=%0d got=%h want=%h", cyc, act_a, {4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_soak();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            req = req ^ 4'($urandom & $urandom);
            tick();
            n_cmp++;
            if (act_a !== exp_vec(m_a) || act_b !== exp_vec(m_b)) begin
                n_bad++;
                $display("FAIL soak_model cyc=%0d req=%b got=%h/%h want=%h/%h", cyc, req, act_a, act_b, exp_vec(m_a), exp_vec(m_b));
            end
            n_cmp++;
            if (!$onehot0(grant_a) || !$onehot0(grant_b) || (oe_a & ~grant_a) != 4'b0 ||
                (oe_b & ~grant_b) != 4'b0 || (busy_a && turn_a) || (busy_b && turn_b)) begin
                n_bad++;
                $display("FAIL soak_invariant cyc=%0d got=%h/%h want=onehot0,oe<=grant,!(busy&turn)", cyc, act_a, act_b);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        req = 4'b0;
        m_a = M_RESET;
        m_b = M_RESET;
        #1;
        test_reset();
        test_lone();
        test_contention();
        test_early_release();
        test_wrap();
        test_idle();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Round-robin arbiter that shares one tristate data bus among NREQ requesters. It issues a registered one-hot grant and per-requester output enables. It limits each tenure to MAX_BURST cycles when others are waiting, and inserts TA_CYCLES dead cycles between owners so no two drivers ever overlap on the bus. It replaces the fixed-priority select logic in front of the bus_with_tristate datapath.

Parameters:
NREQ, 4, number of requesters (2..16)
MAX_BURST, 4, max consecutive grant cycles while another request is pending (>=1)
TA_CYCLES, 1, bus turnaround (all drivers off) cycles between tenures (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  NREQ  request per requester, level, held while bus is wanted
grant  out  NREQ  registered one-hot grant, 0 when bus is unowned
bus_oe  out  NREQ  tristate driver enable per requester; equals grant in OWN, else 0
owner  out  clog2(NREQ)  index of current owner; valid only when busy=1, else 0
busy  out  1  1 in OWN
turnaround  out  1  1 in TURN

Behaviour:
- All outputs are registered. While rst=0 (asynchronous): state=IDLE, grant=0, bus_oe=0, owner=0, busy=0, turnaround=0, rr pointer ptr=0, burst_cnt=0, ta_cnt=0.
- RR pick: the first set bit of req, scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1 (wraps).
- IDLE: if req!=0 at an edge -> OWN after that edge, owner=pick, burst_cnt=1. Latency is 1 edge from sampled req to grant.
- OWN, evaluated each edge, in priority order:
  - req[owner]=0 -> TURN, ptr=(owner+1) mod NREQ.
  - Else burst_cnt==MAX_BURST and (req & ~grant)!=0 -> TURN, ptr=(owner+1) mod NREQ.
  - Else burst_cnt==MAX_BURST with no others pending -> stay in OWN, burst_cnt=1. There is no turnaround for a lone requester.
  - Else burst_cnt++.
- TURN: grant=0, bus_oe=0, lasting exactly TA_CYCLES cycles (ta_cnt loaded with TA_CYCLES-1 on entry). On the final edge: if req!=0 -> OWN directly with pick from the updated ptr, burst_cnt=1; else -> IDLE.
- A requester that re-raises req during TURN competes normally; ptr already points past it.
- Requests that drop before being sampled are ignored. Grant is never revoked mid-cycle.
- Invariants: grant is zero or one-hot; bus_oe is a subset of grant; busy and turnaround are never both 1; a grant never moves between two owners without at least TA_CYCLES all-zero cycles.
- Reset asserted mid-OWN or mid-TURN forces all enables off immediately (asynchronous). The first tenure after reset starts from ptr=0.

Decomposition:
- Shared package/header bus_arb_pkg: state encoding (IDLE, OWN, TURN), clog2 function, index-width constant.
- One combinational sub-module rr_priority_pick (NREQ param). Inputs: req, ptr. Outputs: one-hot, index, any. Registers, counters and FSM live in bus_rr_arbiter.

Test Plan:
1. Reset: hold req=0001, pulse rst low during OWN -> grant/bus_oe=0000 with no clock edge needed. After rst=1, grant=0001 one edge later, owner=0.
2. Lone requester: req=0010 held 12 cycles -> grant=0010 continuously, busy=1, turnaround never 1, burst_cnt wraps 4->1.
3. Contention: req=0011 from first edge after reset -> grant 0001 x4, 0000 x1 (turnaround=1), 0010 x4, 0000 x1, 0001 x4, repeating.
4. Early release: req=0101, owner 0. Drop req[0] after 2 grant cycles -> next cycle grant=0000 turnaround=1, then grant=0100, owner=2.
5. Wrap-around: owner=3 with req=1001, burst expires -> TURN, then grant=0001 (ptr wrapped to 0). Also check the TA_CYCLES=3 build gives exactly 3 zero cycles.
6. Idle fall-through: owner drops req with req=0000 -> TURN then IDLE (busy=0). New req=1000 raised in IDLE -> grant=1000 one edge later. A random-request soak checks the invariants every cycle.
